// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/response bus between the MEM-stage controller and memory.
// One request per transaction; the response returns read data or a write acknowledge.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// RV32I MEM-stage sequencer: runs each load/store as a valid/ready bus transaction,
// stalls the pipeline meanwhile, aligns/extends load data and flags bad accesses.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int TO_W        = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_rd,
  input  logic                mem_wr,
  input  logic [2:0]          funct3,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic                stall,
  mem_access_ctrl_if.master   bus,
  output logic [31:0]         load_data,
  output logic                mem_exc,
  output logic                bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t          state, state_nxt;
  logic [TO_W-1:0] cnt;
  logic [31:0]     data_q;
  logic            err_q;

  logic acc, is_store, illegal, misaligned, pend;
  logic to_hit, to_evt, cap_evt;

  // Access decode; mem_rd wins when both strobes are set.
  assign acc      = mem_rd | mem_wr;
  assign is_store = mem_wr & ~mem_rd;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    illegal = 1'b1;
    if (is_store) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: illegal = 1'b0;
        default:                illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
        default:                                illegal = 1'b1;
      endcase
    end
  end

  assign misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                      ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  assign mem_exc    = acc & (illegal | misaligned);
  assign pend       = acc & ~mem_exc;

  assign to_hit  = (cnt == TO_W'(TIMEOUT_CYC - 1));
  // No response can complete in REQ, so the count limit alone decides there.
  assign to_evt  = ((state == REQ) & to_hit) | ((state == WAIT) & to_hit & ~bus.rsp_valid);
  assign cap_evt = (state == WAIT) & bus.rsp_valid;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pend) state_nxt = REQ;
      REQ: begin
        if (to_hit)                              state_nxt = DONE;
        else if (bus.req_valid && bus.req_ready) state_nxt = WAIT;
      end
      WAIT: if (bus.rsp_valid || to_hit) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Timeout counter, captured load word and timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == REQ || state == WAIT) cnt <= cnt + TO_W'(1);
      else                               cnt <= '0;

      if (to_evt)                    data_q <= '0;
      else if (cap_evt && !is_store) data_q <= bus.rsp_rdata;

      if (state == REQ || state == WAIT) err_q <= to_evt;
      else if (state == IDLE)            err_q <= 1'b0;
    end
  end

  // Output decode: bus request fields, stall, extended load result.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    bus.req_valid = (state == REQ);
    bus.req_we    = is_store;
    bus.req_addr  = {addr[31:2], 2'b00};
    bus.req_be    = 4'b1111;
    bus.req_wdata = wdata;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          bus.req_be    = 4'b0001 << addr[1:0];
          bus.req_wdata = {4{wdata[7:0]}};
        end
        2'b01: begin
          bus.req_be    = addr[1] ? 4'b1100 : 4'b0011;
          bus.req_wdata = {2{wdata[15:0]}};
        end
        default: begin
          bus.req_be    = 4'b1111;
          bus.req_wdata = wdata;
        end
      endcase
    end

    // The reset term keeps stall low while reset is held, whatever the inputs say.
    stall   = pend & (state != DONE) & rst;
    bus_err = (state == DONE) & err_q;

    case (addr[1:0])
      2'b00:   ld_byte = data_q[7:0];
      2'b01:   ld_byte = data_q[15:8];
      2'b10:   ld_byte = data_q[23:16];
      default: ld_byte = data_q[31:24];
    endcase
    ld_half = addr[1] ? data_q[31:16] : data_q[15:0];

    load_data = '0;
    if (state == DONE && !err_q) begin
      case (funct3)
        3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
        3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
        3'b100:  load_data = {24'd0, ld_byte};
        3'b101:  load_data = {16'd0, ld_half};
        default: load_data = data_q;
      endcase
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences the MEM stage of the RV32I pipeline.
- Consumes the EX/MEM pipeline register outputs and runs each load/store as a multi-cycle transaction on a valid/ready data-memory bus.
- Generates the pipeline stall that gates the pipeline-register enables, aligns and extends load data per funct3, builds store byte-enables, and flags misaligned/illegal accesses and bus timeouts.

Parameters:
- TIMEOUT_CYC, 64: cycles allowed in REQ+WAIT before abort; must be ≥2.
- TO_W, 7: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low (asserted when 0).
- mem_rd  in  1  load in MEM stage.
- mem_wr  in  1  store in MEM stage; mem_rd=mem_wr=1 is treated as a load.
- funct3  in  3  access size/sign.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (rs2 value).
- stall  out  1  1 = hold all pipeline registers (enable = ~stall).
- req_valid  out  1  bus request valid.
- req_ready  in  1  bus accepts request.
- req_we  out  1  1 = write.
- req_addr  out  32  {addr[31:2],2'b00}.
- req_be  out  4  byte enables.
- req_wdata  out  32  lane-aligned store data.
- rsp_valid  in  1  read data / write ack valid.
- rsp_rdata  in  32  read data word.
- load_data  out  32  extended load result; valid in DONE.
- mem_exc  out  1  misaligned or illegal funct3 (combinational).
- bus_err  out  1  timeout pulse, one cycle, in DONE.

Behaviour:
- Access decode: acc = mem_rd|mem_wr.
- Legal funct3, load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal funct3, store: 000 SB, 001 SH, 010 SW.
- Any other funct3 is illegal.
- Misaligned: half access with addr[0]=1, or word access with addr[1:0]≠0.
- mem_exc = acc & (illegal | misaligned).
- pend = acc & ~mem_exc. An excepting access never touches the bus and never stalls.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: if pend, go to REQ. rsp_valid is ignored.
- REQ: req_valid=1. On req_valid&req_ready, go to WAIT.
- WAIT: on rsp_valid, capture rsp_rdata into the data register (loads only) and go to DONE.
- DONE: one cycle, then IDLE.
- Timeout counter: cleared on entry to REQ; increments each cycle in REQ/WAIT. When it equals TIMEOUT_CYC-1 without completion, go to DONE with bus_err=1; the captured data is forced to 0 and req_valid drops.
- stall = pend & (state≠DONE). It is combinational on the inputs, so it asserts in the same cycle the access reaches MEM.
- Pipeline advances at the end of the DONE cycle. The next instruction is evaluated in the following IDLE cycle, so back-to-back accesses each run a full sequence.
- Minimum latency, with req_ready=1 in REQ and rsp_valid on the first WAIT cycle: 4 cycles (IDLE, REQ, WAIT, DONE), stall high for 3 cycles.
- A rsp_valid in the same cycle as the REQ handshake is not accepted; the response must come in a WAIT cycle.
- req_addr, req_we, req_be and req_wdata are combinational from the held inputs and are meaningful only while req_valid=1.
- req_we = mem_wr & ~mem_rd.
- Store byte enables:
  - SB: be = 1<<addr[1:0]; wdata[7:0] replicated to all 4 lanes.
  - SH: be = addr[1] ? 1100 : 0011; wdata[15:0] replicated to both halves.
  - SW: be = 1111; wdata unchanged.
- Loads drive be=1111.
- load_data: byte/half selected from the captured word by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through. Driven 0 outside DONE or on bus_err.
- Reset (rst=0, any state, including mid-transaction): state goes to IDLE, counter=0, data register=0. While asserted, req_valid=0, stall=0, load_data=0 and bus_err=0. A response arriving after reset release is ignored in IDLE.
- Inputs must be held stable while stall=1; the pipeline guarantees this.

Test Plan:
- LW addr=0x100, req_ready=1, rsp_rdata=0xDEADBEEF on the first WAIT cycle -> stall high 3 cycles; req_addr=0x100, be=1111; load_data=0xDEADBEEF in DONE.
- LB addr=0x103, rsp_rdata=0x80FFFFFF -> load_data=0xFFFFFF80.
- LBU at the same address -> load_data=0x00000080.
- SH addr=0x202, wdata=0x1234ABCD -> req_we=1, be=1100, req_wdata=0xABCDABCD, req_addr=0x200; completes on the write ack.
- LW addr=0x101 -> mem_exc=1, stall=0, req_valid never asserted.
- funct3=011 with mem_rd=1 -> mem_exc=1, no bus request.
- req_ready held 0 with TIMEOUT_CYC=8 -> req_valid high 8 cycles; DONE with bus_err=1 for one cycle, load_data=0; next cycle IDLE.
- rst=0 pulsed during WAIT -> req_valid=0 and stall=0 immediately.
- After release, a late rsp_valid is ignored, and a new LW completes normally.
